lcd_rgb_timing_rx: RTL and testbench

LCD_RGB_TIMING_RX -- requirements
Module: lcd_rgb_timing_rx

---
 rtl/lcd_rgb_timing_rx.sv | 180 ++++++++++++++++++
 tb/tb_lcd_rgb_timing_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_rgb_timing_rx.sv
// Parallel RGB LCD receiver: registers pixels with their x/y position and
// locks onto the active geometry once two identical complete frames are seen.
module lcd_rgb_timing_rx #(
  parameter int SYNC_POL = 0,
  parameter int CNT_W    = 11
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             lcd_de,
  input  logic             lcd_hs,
  input  logic             lcd_vs,
  input  logic [23:0]      lcd_rgb,
  output logic             pix_valid,
  output logic [23:0]      pix_data,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             frame_start,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_active,
  output logic             locked,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  state_t           r_state, w_state_next;
  logic             r_vs_act_d, r_de_d;
  logic             r_pix_valid, r_frame_start, r_locked;
  logic [23:0]      r_pix_data;
  logic [CNT_W-1:0] r_pix_x, r_pix_y, r_h_active, r_v_active;
  logic [CNT_W-1:0] r_len, r_line, r_ref, r_cand_h, r_cand_v;
  logic             r_mis;
  logic [7:0]       r_err_cnt;

  logic             w_vs_act, w_vs_edge, w_de_rise, w_de_fall;
  logic [CNT_W-1:0] w_line_end, w_ref_end;
  logic             w_mis_end, w_frame_ok, w_eq_cand, w_eq_lock, w_len_bad;
  logic             w_cand_load, w_lock_load, w_lock_exit;
  logic             w_unused_hs;

  assign w_unused_hs = lcd_hs;
  assign w_vs_act    = (SYNC_POL != 0) ? lcd_vs : ~lcd_vs;
  assign w_vs_edge   = w_vs_act & ~r_vs_act_d;
  assign w_de_rise   = lcd_de & ~r_de_d;
  assign w_de_fall   = ~lcd_de & r_de_d;

  // A line ending together with vs_edge still belongs to the frame being closed.
  assign w_line_end = w_de_fall ? sat_inc(r_line) : r_line;
  assign w_ref_end  = (w_de_fall && (r_line == CNT_ZERO)) ? r_len : r_ref;
  assign w_mis_end  = r_mis | (w_de_fall && (r_line != CNT_ZERO) && (r_len != r_ref));
  assign w_frame_ok = (w_line_end != CNT_ZERO) && !w_mis_end;
  assign w_eq_cand  = (w_ref_end == r_cand_h) && (w_line_end == r_cand_v);
  assign w_eq_lock  = (w_ref_end == r_h_active) && (w_line_end == r_v_active);
  assign w_len_bad  = w_de_fall && (r_len != r_h_active);

  // Next-state logic for the lock acquisition state machine
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_SYNC: begin
        if (w_vs_edge) w_state_next = ST_MEASURE;
        else           w_state_next = r_state;
      end
      ST_MEASURE: begin
        if (w_vs_edge && w_frame_ok) w_state_next = ST_CONFIRM;
        else                         w_state_next = r_state;
      end
      ST_CONFIRM: begin
        if (!w_vs_edge)      w_state_next = r_state;
        else if (!w_frame_ok) w_state_next = ST_MEASURE;
        else if (w_eq_cand)  w_state_next = ST_LOCKED;
        else                 w_state_next = ST_CONFIRM;
      end
      ST_LOCKED: begin
        if (w_len_bad)                                w_state_next = ST_SYNC;
        else if (w_vs_edge && !(w_frame_ok && w_eq_lock)) w_state_next = ST_MEASURE;
        else                                          w_state_next = ST_LOCKED;
      end
      default: w_state_next = ST_SYNC;
    endcase
  end

  assign w_cand_load = w_vs_edge && w_frame_ok &&
                       ((r_state == ST_MEASURE) || ((r_state == ST_CONFIRM) && !w_eq_cand));
  assign w_lock_load = (r_state == ST_CONFIRM) && (w_state_next == ST_LOCKED);
  assign w_lock_exit = (r_state == ST_LOCKED) && (w_state_next != ST_LOCKED);

  // Input edge history, pixel capture and position outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_vs_act_d    <= 1'b0;
      r_de_d        <= 1'b0;
      r_pix_valid   <= 1'b0;
      r_pix_data    <= 24'h000000;
      r_pix_x       <= CNT_ZERO;
      r_pix_y       <= CNT_ZERO;
      r_frame_start <= 1'b0;
    end else begin
      r_vs_act_d    <= w_vs_act;
      r_de_d        <= lcd_de;
      r_pix_valid   <= lcd_de;
      r_frame_start <= w_vs_edge;
      if (lcd_de) begin
        r_pix_data <= lcd_rgb;
        r_pix_y    <= w_vs_edge ? CNT_ZERO : r_line;
        r_pix_x    <= w_de_rise ? CNT_ZERO : sat_inc(r_pix_x);
      end
    end
  end

  // Per-frame measurement: line length, line count, reference length, mismatch
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_len  <= CNT_ZERO;
      r_line <= CNT_ZERO;
      r_ref  <= CNT_ZERO;
      r_mis  <= 1'b0;
    end else begin
      if (w_de_rise)   r_len <= CNT_ONE;
      else if (lcd_de) r_len <= sat_inc(r_len);
      if (w_vs_edge) begin
        r_line <= CNT_ZERO;
        r_mis  <= 1'b0;
      end else if (w_de_fall) begin
        r_line <= w_line_end;
        r_ref  <= w_ref_end;
        r_mis  <= w_mis_end;
      end
    end
  end

  // State register, candidate/locked geometry and lock-loss counter
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= ST_SYNC;
      r_locked   <= 1'b0;
      r_cand_h   <= CNT_ZERO;
      r_cand_v   <= CNT_ZERO;
      r_h_active <= CNT_ZERO;
      r_v_active <= CNT_ZERO;
      r_err_cnt  <= 8'd0;
    end else begin
      r_state  <= w_state_next;
      r_locked <= (w_state_next == ST_LOCKED);
      if (w_cand_load) begin
        r_cand_h <= w_ref_end;
        r_cand_v <= w_line_end;
      end
      if (w_lock_load) begin
        r_h_active <= w_ref_end;
        r_v_active <= w_line_end;
      end
      if (w_lock_exit && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign pix_valid   = r_pix_valid;
  assign pix_data    = r_pix_data;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign frame_start = r_frame_start;
  assign h_active    = r_h_active;
  assign v_active    = r_v_active;
  assign locked      = r_locked;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_lcd_rgb_timing_rx.sv
// Bench for lcd_rgb_timing_rx: directed frame sequences with random pixel data
// and sync noise, checked every cycle against a frame-level reference model.
module tb_lcd_rgb_timing_rx;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        lcd_de, lcd_hs, lcd_vs;
  logic [23:0] lcd_rgb;
  logic        pix_valid, frame_start, locked;
  logic [23:0] pix_data;
  logic [10:0] pix_x, pix_y, h_active, v_active;
  logic [7:0]  err_cnt;

  lcd_rgb_timing_rx dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .lcd_de(lcd_de), .lcd_hs(lcd_hs),
    .lcd_vs(lcd_vs), .lcd_rgb(lcd_rgb), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start), .h_active(h_active),
    .v_active(v_active), .locked(locked), .err_cnt(err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int n_asrt = 0;
  int n_fail = 0;

  // reference model state
  bit          m_vs_prev, m_de_prev, m_mis, m_locked, m_sync;
  int          m_col, m_lines, m_ref, m_x, m_y, m_err, m_h, m_v, m_run, m_ch, m_cv;
  logic [23:0] m_data;
  bit          g_ramp;
  int          pix_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_data"}, 32'(pix_data), 32'd0);
    chk({tag, "_x"}, 32'(pix_x), 32'd0);
    chk({tag, "_y"}, 32'(pix_y), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
    chk({tag, "_h"}, 32'(h_active), 32'd0);
    chk({tag, "_v"}, 32'(v_active), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_err"}, 32'(err_cnt), 32'd0);
  endtask

  task automatic model_reset();
    m_vs_prev = 0; m_de_prev = 0; m_mis = 0; m_locked = 0; m_sync = 1;
    m_col = 0; m_lines = 0; m_ref = 0; m_x = 0; m_y = 0; m_err = 0;
    m_h = 0; m_v = 0; m_run = 0; m_ch = 0; m_cv = 0; m_data = 24'h0;
  endtask

  // Lock tracking as a streak of consecutive identical good frames.
  task automatic model_frame_end(input bit ok, input int h, input int v);
    if (m_sync) begin
      m_sync = 0; m_run = 0;
    end else if (m_locked) begin
      if (!(ok && h == m_h && v == m_v)) begin
        m_locked = 0; m_run = 0;
        m_err = (m_err < 255) ? m_err + 1 : 255;
      end
    end else if (!ok) begin
      m_run = 0;
    end else if (m_run == 1 && h == m_ch && v == m_cv) begin
      m_locked = 1; m_h = h; m_v = v; m_run = 0;
    end else begin
      m_run = 1; m_ch = h; m_cv = v;
    end
  endtask

  task automatic step(input bit vs_act, input bit de, input logic [23:0] rgb);
    bit ev_vs, ev_fall;
    int len;
    lcd_vs  = vs_act ? 1'b0 : 1'b1;
    lcd_de  = de;
    lcd_rgb = rgb;
    lcd_hs  = 1'($urandom_range(0, 1));
    ev_vs   = vs_act && !m_vs_prev;
    ev_fall = !de && m_de_prev;
    if (de) begin
      m_col  = m_de_prev ? ((m_col < 2047) ? m_col + 1 : m_col) : 0;
      m_x    = m_col;
      m_y    = m_lines;
      m_data = rgb;
    end
    if (ev_fall) begin
      len = m_col + 1;
      if (m_lines == 0) m_ref = len;
      else if (len != m_ref) m_mis = 1;
      if (m_locked && len != m_h) begin
        m_locked = 0; m_sync = 1; m_run = 0;
        m_err = (m_err < 255) ? m_err + 1 : 255;
      end
      m_lines++;
    end
    if (ev_vs) begin
      model_frame_end(m_lines > 0 && !m_mis, m_ref, m_lines);
      m_lines = 0; m_mis = 0;
    end
    m_vs_prev = vs_act;
    m_de_prev = de;
    @(posedge sys_clk); #1;
    chk("pix_valid", 32'(pix_valid), 32'(de));
    chk("pix_data", 32'(pix_data), 32'(m_data));
    chk("pix_x", 32'(pix_x), 32'(m_x));
    chk("pix_y", 32'(pix_y), 32'(m_y));
    chk("frame_start", 32'(frame_start), 32'(ev_vs));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("err_cnt", 32'(err_cnt), 32'(m_err));
    chk("h_active", 32'(h_active), 32'(m_h));
    chk("v_active", 32'(v_active), 32'(m_v));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'($urandom));
  endtask

  task automatic vsync();
    pix_idx = 0;
    step(1'b1, 1'b0, 24'($urandom));
    idle(2);
  endtask

  task automatic line(input int len);
    for (int i = 0; i < len; i++) begin
      step(1'b0, 1'b1, g_ramp ? 24'(pix_idx) : 24'($urandom));
      pix_idx++;
    end
  endtask

  task automatic frame(input int h, input int v, input int tail, input int bad_row, input int bad_len);
    vsync();
    for (int r = 0; r < v; r++) begin
      line((r == bad_row) ? bad_len : h);
      if (r < v - 1) idle(2);
      else idle(tail);
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    lcd_vs = 1'b1; lcd_de = 1'b0; lcd_hs = 1'b0; lcd_rgb = 24'h0;
    g_ramp = 1'b1; pix_idx = 0;
    model_reset();
    #12;
    chk_zero("reset");
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    idle(3);

    // three identical 8x4 frames, ramp data
    for (int f = 0; f < 3; f++) frame(8, 4, 2, -1, 0);
    chk("lock_8x4", 32'(locked), 32'd1);
    chk("lock_h8", 32'(h_active), 32'd8);
    chk("lock_v4", 32'(v_active), 32'd4);
    chk("lock_err0", 32'(err_cnt), 32'd0);
    g_ramp = 1'b0;

    // last de_fall coincides with the next vs_edge
    frame(8, 4, 0, -1, 0);
    frame(8, 4, 2, -1, 0);
    chk("simul_edge_locked", 32'(locked), 32'd1);

    // short line in row 2 while locked
    frame(8, 4, 2, 2, 7);
    chk("short_line_locked", 32'(locked), 32'd0);
    chk("short_line_err", 32'(err_cnt), 32'd1);
    chk("short_line_h_held", 32'(h_active), 32'd8);

    for (int f = 0; f < 3; f++) frame(8, 4, 2, -1, 0);
    chk("relock_8x4", 32'(locked), 32'd1);

    // geometry change to 8x5
    frame(8, 5, 2, -1, 0);
    frame(8, 5, 2, -1, 0);
    chk("geom_change_locked", 32'(locked), 32'd0);
    chk("geom_change_err", 32'(err_cnt), 32'd2);
    frame(8, 5, 2, -1, 0);
    frame(8, 5, 2, -1, 0);
    chk("relock_8x5", 32'(locked), 32'd1);
    chk("relock_v5", 32'(v_active), 32'd5);

    // reset pulsed mid-frame while locked
    vsync();
    line(8); idle(2); line(8); idle(1);
    sys_rst_n = 1'b0;
    #1;
    chk_zero("rst_mid_async");
    model_reset();
    @(posedge sys_clk); #1;
    chk_zero("rst_mid_held");
    sys_rst_n = 1'b1;
    line(8); idle(2); line(8); idle(2);
    frame(8, 5, 2, -1, 0);
    frame(8, 5, 2, -1, 0);
    chk("rst_no_early_lock", 32'(locked), 32'd0);
    frame(8, 5, 2, -1, 0);
    chk("rst_relock", 32'(locked), 32'd1);
    chk("rst_err0", 32'(err_cnt), 32'd0);

    // 257 lock losses with alternating tiny geometries
    for (int k = 0; k < 257; k++)
      for (int j = 0; j < 3; j++) frame((k % 2 == 1) ? 2 : 1, 1, 2, -1, 0);
    vsync();
    chk("err_saturated", 32'(err_cnt), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
